// File: rtl/mutative_miss_handler.sv
// Cache miss handler: optional dirty-victim writeback, line fetch, a single
// array fill cycle with a PLRU touch, then a one-cycle done pulse.
// Saturating counters track accepted misses and writebacks.
module mutative_miss_handler #(
  parameter int WAYS         = 8,
  parameter int WAY_IDX_BITS = 3,
  parameter int LINE_BITS    = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    miss_req,
  input  logic [31:0]             miss_addr,
  input  logic [WAY_IDX_BITS-1:0] evict_way,
  input  logic                    victim_valid,
  input  logic                    victim_dirty,
  input  logic [31:0]             victim_addr,
  input  logic [LINE_BITS-1:0]    victim_data,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [31:0]             mem_addr,
  output logic [LINE_BITS-1:0]    mem_wdata,
  input  logic [LINE_BITS-1:0]    mem_rdata,
  input  logic                    mem_resp,
  output logic [WAYS-1:0]         fill_we,
  output logic [LINE_BITS-1:0]    fill_data,
  output logic [31:0]             fill_addr,
  output logic                    plru_touch,
  output logic [WAY_IDX_BITS-1:0] plru_way,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             miss_cnt,
  output logic [15:0]             wb_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WB    = 3'd1,
    S_FETCH = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [31:0]             miss_addr_q;
  logic [31:0]             victim_addr_q;
  logic [LINE_BITS-1:0]    victim_data_q;
  logic [WAY_IDX_BITS-1:0] way_q;
  logic [LINE_BITS-1:0]    fill_data_q;
  logic [31:0]             fill_addr_q;
  logic [WAY_IDX_BITS-1:0] plru_way_q;
  logic [15:0]             miss_cnt_q, miss_cnt_d;
  logic [15:0]             wb_cnt_q, wb_cnt_d;
  logic                    accept_s;
  logic                    wb_needed_s;
  logic                    fetch_done_s;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  // One-hot way select for the fill write enable.
  function automatic logic [WAYS-1:0] way_onehot(input logic [WAY_IDX_BITS-1:0] w);
    way_onehot = {{(WAYS-1){1'b0}}, 1'b1} << w;
  endfunction

  // A miss is only taken in IDLE; requests while busy are ignored.
  assign accept_s     = (state_q == S_IDLE) && miss_req;
  // An invalid victim never needs writing back, whatever its dirty bit says.
  assign wb_needed_s  = victim_valid && victim_dirty;
  assign fetch_done_s = (state_q == S_FETCH) && mem_resp;

  assign fill_data = fill_data_q;
  assign fill_addr = fill_addr_q;
  assign plru_way  = plru_way_q;
  assign miss_cnt  = miss_cnt_q;
  assign wb_cnt    = wb_cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; mem_resp only matters in WB and FETCH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = wb_needed_s ? S_WB : S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        if (mem_resp) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_FETCH: begin
        if (mem_resp) begin
          state_d = S_FILL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FILL:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state and latched miss context.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = {LINE_BITS{1'b0}};
    fill_we    = {WAYS{1'b0}};
    plru_touch = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_WB: begin
        mem_write = 1'b1;
        mem_addr  = victim_addr_q;
        mem_wdata = victim_data_q;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        mem_addr = miss_addr_q;
      end
      S_FILL: begin
        fill_we    = way_onehot(plru_way_q);
        plru_touch = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Saturating miss / writeback counter next values.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (accept_s) begin
      miss_cnt_d = sat_inc(miss_cnt_q);
      if (wb_needed_s) begin
        wb_cnt_d = sat_inc(wb_cnt_q);
      end else begin
        wb_cnt_d = wb_cnt_q;
      end
    end else begin
      miss_cnt_d = miss_cnt_q;
      wb_cnt_d   = wb_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= 16'd0;
      wb_cnt_q   <= 16'd0;
    end else begin
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  // Latch the miss context on acceptance; the fill outputs load when the
  // fetch completes and then hold until the next fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_addr_q   <= 32'd0;
      victim_addr_q <= 32'd0;
      victim_data_q <= {LINE_BITS{1'b0}};
      way_q         <= {WAY_IDX_BITS{1'b0}};
      fill_data_q   <= {LINE_BITS{1'b0}};
      fill_addr_q   <= 32'd0;
      plru_way_q    <= {WAY_IDX_BITS{1'b0}};
    end else begin
      if (accept_s) begin
        miss_addr_q   <= miss_addr;
        victim_addr_q <= victim_addr;
        victim_data_q <= victim_data;
        way_q         <= evict_way;
      end
      if (fetch_done_s) begin
        fill_data_q <= mem_rdata;
        fill_addr_q <= miss_addr_q;
        plru_way_q  <= way_q;
      end
    end
  end

endmodule

// File: tb/tb_mutative_miss_handler.sv
// Self-checking bench for mutative_miss_handler: cycle-accurate memory
// handshake checks per miss plus a fill scoreboard fed at issue time.
module tb_mutative_miss_handler;

  logic         clk, rst_n, miss_req;
  logic [31:0]  miss_addr;
  logic [2:0]   evict_way;
  logic         victim_valid, victim_dirty;
  logic [31:0]  victim_addr;
  logic [255:0] victim_data;
  logic         mem_read, mem_write;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [7:0]   fill_we;
  logic [255:0] fill_data;
  logic [31:0]  fill_addr;
  logic         plru_touch;
  logic [2:0]   plru_way;
  logic         busy, done;
  logic [15:0]  miss_cnt, wb_cnt;

  typedef struct {
    logic [7:0]   we;
    logic [255:0] data;
    logic [31:0]  addr;
    logic [2:0]   way;
  } fill_t;

  fill_t       fill_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_miss = 16'd0;
  logic [15:0] exp_wb   = 16'd0;

  mutative_miss_handler #(.WAYS(8), .WAY_IDX_BITS(3), .LINE_BITS(256)) dut (
    .clk(clk), .rst_n(rst_n), .miss_req(miss_req), .miss_addr(miss_addr),
    .evict_way(evict_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_addr(victim_addr), .victim_data(victim_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .fill_we(fill_we), .fill_data(fill_data), .fill_addr(fill_addr),
    .plru_touch(plru_touch), .plru_way(plru_way), .busy(busy), .done(done),
    .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] noise();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Disturb request-side inputs while the handler is busy.
  task automatic scramble();
    miss_req     = 1'($urandom_range(0, 1));
    miss_addr    = $urandom();
    evict_way    = 3'($urandom_range(0, 7));
    victim_valid = 1'($urandom_range(0, 1));
    victim_dirty = 1'($urandom_range(0, 1));
    victim_addr  = $urandom();
    victim_data  = noise();
  endtask

  // Fill scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk) begin
    fill_t f;
    chk("rw_excl", 256'(mem_read & mem_write), 256'(1'b0));
    chk("touch_vs_we", 256'(plru_touch), 256'(fill_we != 8'd0));
    if (fill_we != 8'd0) begin
      if (fill_q.size() == 0) begin
        chk("fill_unexpected", 256'(fill_we), 256'(8'd0));
      end else begin
        f = fill_q.pop_front();
        chk("fill_we",   256'(fill_we),   256'(f.we));
        chk("fill_data", fill_data,       f.data);
        chk("fill_addr", 256'(fill_addr), 256'(f.addr));
        chk("plru_way",  256'(plru_way),  256'(f.way));
      end
    end
  end

  // Run one miss starting at a falling edge in IDLE (that cycle is cycle 0).
  task automatic do_miss(input logic [31:0] maddr, input logic [2:0] way,
                         input logic vv, input logic vd, input logic [31:0] vaddr,
                         input logic [255:0] vdata, input logic [255:0] rdata,
                         input int wb_wait, input int rd_wait, input bit zw, input bit noisy);
    fill_t f;
    logic dirty;
    dirty = vv & vd;
    chk("start_idle", 256'(busy), 256'(1'b0));
    miss_req = 1'b1; miss_addr = maddr; evict_way = way; victim_valid = vv;
    victim_dirty = vd; victim_addr = vaddr; victim_data = vdata; mem_resp = zw;
    f.we = 8'd1 << way; f.data = rdata; f.addr = maddr; f.way = way;
    fill_q.push_back(f);
    exp_miss = sat(exp_miss);
    if (dirty) exp_wb = sat(exp_wb);
    @(negedge clk);
    if (dirty) begin
      for (int i = 1; i <= wb_wait; i++) begin
        chk("wb_write", 256'(mem_write), 256'(1'b1));
        chk("wb_read",  256'(mem_read),  256'(1'b0));
        chk("wb_addr",  256'(mem_addr),  256'(vaddr));
        chk("wb_data",  mem_wdata,       vdata);
        if (noisy) scramble();
        mem_resp = zw || (i == wb_wait);
        @(negedge clk);
      end
    end
    for (int i = 1; i <= rd_wait; i++) begin
      chk("rd_read",  256'(mem_read),  256'(1'b1));
      chk("rd_write", 256'(mem_write), 256'(1'b0));
      chk("rd_addr",  256'(mem_addr),  256'(maddr));
      chk("rd_busy",  256'(busy),      256'(1'b1));
      if (noisy) scramble();
      mem_resp  = zw || (i == rd_wait);
      mem_rdata = (i == rd_wait) ? rdata : noise();
      @(negedge clk);
    end
    // FILL cycle: a response here must be ignored.
    mem_resp  = noisy | zw;
    mem_rdata = noise();
    chk("fill_done", 256'(done), 256'(1'b0));
    chk("fill_busy", 256'(busy), 256'(1'b1));
    chk("fill_rd",   256'(mem_read | mem_write), 256'(1'b0));
    @(negedge clk);
    chk("done_pulse", 256'(done), 256'(1'b1));
    chk("done_busy",  256'(busy), 256'(1'b1));
    miss_req = 1'b0;
    @(negedge clk);
    chk("end_done",  256'(done),     256'(1'b0));
    chk("end_busy",  256'(busy),     256'(1'b0));
    chk("miss_cnt",  256'(miss_cnt), 256'(exp_miss));
    chk("wb_cnt",    256'(wb_cnt),   256'(exp_wb));
    mem_resp = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; miss_req = 1'b0; miss_addr = 32'd0; evict_way = 3'd0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_addr = 32'd0;
    victim_data = 256'd0; mem_rdata = 256'd0; mem_resp = 1'b0;
    #1;
    chk("rst_busy",  256'(busy),     256'(1'b0));
    chk("rst_rw",    256'(mem_read | mem_write), 256'(1'b0));
    chk("rst_fill",  256'(fill_we),  256'(8'd0));
    chk("rst_fdata", fill_data,      256'd0);
    chk("rst_cnt",   256'({miss_cnt, wb_cnt}), 256'(32'd0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean miss, memory responds in cycle 3.
    do_miss(32'h0000_1000, 3'd5, 1'b0, 1'b0, 32'h0, 256'd0, noise(), 1, 3, 1'b0, 1'b0);
    // Dirty miss, two cycles per access.
    do_miss(32'h0000_3000, 3'd2, 1'b1, 1'b1, 32'h0000_2000, noise(), noise(), 2, 2, 1'b0, 1'b0);
    // Invalid-but-dirty victim is clean; valid-clean victim too.
    do_miss(32'h0000_4040, 3'd7, 1'b0, 1'b1, 32'h0000_5000, noise(), noise(), 1, 2, 1'b0, 1'b0);
    do_miss(32'h0000_6080, 3'd0, 1'b1, 1'b0, 32'h0000_7000, noise(), noise(), 1, 1, 1'b0, 1'b0);
    // Zero-wait memory, clean then dirty.
    do_miss(32'h0001_0000, 3'd1, 1'b0, 1'b0, 32'h0, noise(), noise(), 1, 1, 1'b1, 1'b0);
    do_miss(32'h0002_0000, 3'd6, 1'b1, 1'b1, 32'h0003_0000, noise(), noise(), 1, 1, 1'b1, 1'b0);

    // Spurious responses in IDLE.
    mem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur_busy", 256'(busy), 256'(1'b0));
      chk("spur_rw",   256'(mem_read | mem_write), 256'(1'b0));
    end
    mem_resp = 1'b0;
    chk("spur_cnt", 256'({miss_cnt, wb_cnt}), 256'({exp_miss, exp_wb}));

    // Noisy inputs while busy: toggling miss_req, changing victim info.
    for (int n = 0; n < 4; n++) begin
      do_miss($urandom() & 32'hFFFF_FFE0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFE0, noise(), noise(),
              $urandom_range(1, 3), $urandom_range(1, 3), 1'b0, 1'b1);
    end

    // Reset in the middle of FETCH.
    miss_req = 1'b1; miss_addr = 32'h0000_8000; evict_way = 3'd3;
    victim_valid = 1'b0; victim_dirty = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_read", 256'(mem_read), 256'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_read", 256'(mem_read), 256'(1'b0));
    chk("mid_rst_busy", 256'(busy),     256'(1'b0));
    chk("mid_rst_done", 256'(done),     256'(1'b0));
    chk("mid_rst_cnt",  256'({miss_cnt, wb_cnt}), 256'(32'd0));
    chk("mid_rst_fadr", 256'(fill_addr), 256'(32'd0));
    exp_miss = 16'd0; exp_wb = 16'd0; miss_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", 256'(done), 256'(1'b0));
      chk("post_rst_busy", 256'(busy), 256'(1'b0));
    end
    do_miss(32'h0000_9000, 3'd4, 1'b1, 1'b1, 32'h0000_A000, noise(), noise(), 1, 2, 1'b0, 1'b0);

    // Counter saturation.
    force dut.miss_cnt_q = 16'hFFFE;
    #1 release dut.miss_cnt_q;
    exp_miss = 16'hFFFE;
    chk("sat_preload", 256'(miss_cnt), 256'(16'hFFFE));
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      do_miss(32'h0004_0000 + 32'(n) * 32'h40, 3'(n), 1'b0, 1'b0, 32'h0, noise(), noise(),
              1, 1, 1'b1, 1'b0);
    end
    chk("sat_final", 256'(miss_cnt), 256'(16'hFFFF));

    repeat (2) @(negedge clk);
    chk("fill_q_empty", 256'(fill_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mutative_miss_handler.md
MUTATIVE_MISS_HANDLER -- requirements
Module: mutative_miss_handler

Interface
REQ-001 SHALL have parameter WAYS, default 8, physical way count.
REQ-002 SHALL have parameter WAY_IDX_BITS, default 3, way index width (log2 WAYS).
REQ-003 SHALL have parameter LINE_BITS, default 256, cache line width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port miss_req  in  1  miss detected this cycle, refill requested.
REQ-007 SHALL have port miss_addr  in  32  line-aligned address of missing line.
REQ-008 SHALL have port evict_way  in  WAY_IDX_BITS  victim physical way from PLRU stage.
REQ-009 SHALL have port victim_valid  in  1  victim way holds valid line.
REQ-010 SHALL have port victim_dirty  in  1  victim line modified.
REQ-011 SHALL have port victim_addr  in  32  line address of victim line.
REQ-012 SHALL have port victim_data  in  LINE_BITS  victim line contents.
REQ-013 SHALL have ports mem_read, mem_write  out  1 each  memory request strobes.
REQ-014 SHALL have ports mem_addr  out  32 and mem_wdata  out  LINE_BITS  request address/data.
REQ-015 SHALL have ports mem_rdata  in  LINE_BITS and mem_resp  in  1  memory return/acknowledge.
REQ-016 SHALL have ports fill_we  out  WAYS, fill_data  out  LINE_BITS, fill_addr  out  32  array fill write.
REQ-017 SHALL have ports plru_touch  out  1 and plru_way  out  WAY_IDX_BITS  MRU update into PLRU (drives its hit/hit_way).
REQ-018 SHALL have ports busy  out  1, done  out  1, miss_cnt  out  16, wb_cnt  out  16.

Function
REQ-019 SHALL implement FSM states IDLE, WB, FETCH, FILL, DONE; busy=1 in every state except IDLE.
REQ-020 In IDLE with miss_req=1, SHALL latch miss_addr, evict_way, victim_addr, victim_data; next state WB if victim_valid&victim_dirty, else FETCH.
REQ-021 miss_req while busy=1 SHALL be ignored (no latch, no count); requester holds miss_req until done.
REQ-022 WB: mem_write=1, mem_addr=latched victim_addr, mem_wdata=latched victim_data, held constant until mem_resp=1; then FETCH.
REQ-023 FETCH: mem_read=1, mem_addr=latched miss_addr, held until mem_resp=1; mem_rdata captured that cycle; then FILL.
REQ-024 mem_read and mem_write SHALL never be 1 simultaneously; both 0 in IDLE, FILL, DONE.
REQ-025 mem_resp in the first cycle of WB/FETCH SHALL be accepted (zero-wait memory legal).
REQ-026 mem_resp in IDLE, FILL or DONE SHALL be ignored.
REQ-027 FILL (exactly 1 cycle): fill_we = one-hot (1 << latched evict_way), fill_data = captured rdata, fill_addr = latched miss_addr, plru_touch=1, plru_way=latched evict_way; then DONE.
REQ-028 Outside FILL fill_we=0 and plru_touch=0; fill_data/fill_addr/plru_way hold last value.
REQ-029 DONE (exactly 1 cycle): done=1; then IDLE; new miss_req accepted no earlier than the following IDLE cycle.
REQ-030 Latency: miss_req accepted cycle 0; clean victim with mem_resp at cycle k (k>=1) gives FILL at k+1, done at k+2; dirty victim adds WB cycles up to its mem_resp.
REQ-031 miss_cnt SHALL increment by 1 on each accepted miss; wb_cnt on each IDLE->WB transition; both saturate at 16'hFFFF, no wrap.
REQ-032 Invalid victim with dirty=1 SHALL be treated as clean (no writeback).

Reset
REQ-033 rst_n=0 SHALL immediately (asynchronously) force state IDLE, all outputs 0, counters 0, latched registers 0.
REQ-034 Reset asserted in WB/FETCH SHALL drop mem_read/mem_write same cycle; no fill or done is produced for the aborted miss.
REQ-035 After rst_n rises, first edge SHALL evaluate IDLE behaviour.

Verification
REQ-036 Clean miss: miss_req, miss_addr=0x0000_1000, evict_way=5, victim_valid=0, mem_resp at cycle 3 -> mem_read cycles 1-3 addr 0x1000, fill_we=8'b0010_0000 cycle 4, plru_touch way 5, done cycle 5, miss_cnt=1, wb_cnt=0.
REQ-037 Dirty miss: victim_valid=1, dirty=1, victim_addr=0x2000, evict_way=2, resp after 2 cycles each -> mem_write to 0x2000 then mem_read to miss_addr, fill_we=8'b0000_0100, wb_cnt=1.
REQ-038 Zero-wait memory: mem_resp held 1 -> clean miss done at cycle 3, dirty miss done at cycle 4.
REQ-039 miss_req held and toggled during busy, plus spurious mem_resp in IDLE -> exactly one fill per accepted miss, counters unaffected by ignored events.
REQ-040 rst_n low mid-FETCH -> mem_read 0 immediately, no fill_we/done, counters 0; subsequent miss completes normally.
REQ-041 Force miss_cnt to 16'hFFFE, issue 3 misses -> miss_cnt reads 16'hFFFF and stays.
